// File: rtl/rv32i_udp_prg_ctrl_if.sv
// rtl/rv32i_udp_prg_ctrl_if.sv - receive/transmit/imem signal bundle for the program loader
//
// Purpose: groups the frame receiver, ACK transmitter and instruction-memory
// write signals that the loader sequencer talks to.
//
// Signals:
//   data_cmd     receiver -> loader  command word of the current frame
//   data_o       receiver -> loader  payload word
//   data_o_valid receiver -> loader  1-cycle strobe, data_o valid
//   rx_finish    receiver -> loader  1-cycle strobe, frame end
//   tx_finish    transmit -> loader  1-cycle strobe, ACK frame sent
//   imem_we      loader -> imem      write enable pulse
//   imem_addr    loader -> imem      word address
//   imem_wdata   loader -> imem      write data
//   tx_start     loader -> transmit  1-cycle strobe, start ACK
//   tx_status    loader -> transmit  ACK payload
//   rx_release   loader -> receiver  1-cycle strobe to receiver tx_finish input
//
// Modports: master = loader sequencer, slave = surrounding receive/transmit/imem side.

interface rv32i_udp_prg_ctrl_if #(
   parameter int unsigned ADDR_W = 10
);
   logic [31:0]       data_cmd;
   logic [31:0]       data_o;
   logic              data_o_valid;
   logic              rx_finish;
   logic              tx_finish;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              tx_start;
   logic [31:0]       tx_status;
   logic              rx_release;

   modport master (
      input  data_cmd,
      input  data_o,
      input  data_o_valid,
      input  rx_finish,
      input  tx_finish,
      output imem_we,
      output imem_addr,
      output imem_wdata,
      output tx_start,
      output tx_status,
      output rx_release
   );

   modport slave (
      output data_cmd,
      output data_o,
      output data_o_valid,
      output rx_finish,
      output tx_finish,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata,
      input  tx_start,
      input  tx_status,
      input  rx_release
   );
endinterface

// File: rtl/rv32i_udp_prg_ctrl.sv
// rtl/rv32i_udp_prg_ctrl.sv - UDP program loader sequencer for the RV32I core
//
// Purpose: writes received PRG payload words into instruction memory while
// holding the core in reset, decodes the frame command (PRG/RUN/HALT), issues
// one ACK/NAK transmit per frame and then releases the receiver either when
// the transmitter reports completion or after TX_TIMEOUT cycles.
//
// Ports:
//   clk      in   single clock domain (rx nibble clock)
//   rst      in   synchronous, active-high reset
//   bus      if   master side of rv32i_udp_prg_ctrl_if (receiver, transmitter, imem)
//   cpu_rst  out  core reset hold, 1 = held
//   busy     out  sequencer not idle

module rv32i_udp_prg_ctrl #(
   parameter int unsigned ADDR_W     = 10,
   parameter logic [31:0] CMD_PRG    = 32'h50524F47,
   parameter logic [31:0] CMD_RUN    = 32'h52554E21,
   parameter logic [31:0] CMD_HALT   = 32'h48414C54,
   parameter logic [15:0] TX_TIMEOUT = 16'd50000
) (
   input  logic                  clk,
   input  logic                  rst,
   rv32i_udp_prg_ctrl_if.master  bus,
   output logic                  cpu_rst,
   output logic                  busy
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DECODE  = 2'd1;
   localparam logic [1:0] S_WAIT_TX = 2'd2;

   // word_cnt has one extra bit so that a completely filled memory is distinct from empty.
   localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state_q,      state_d;
   logic [ADDR_W:0]   word_cnt_q,   word_cnt_d;
   logic              ovf_q,        ovf_d;
   logic              to_flag_q,    to_flag_d;
   logic              cpu_rst_q,    cpu_rst_d;
   logic              imem_we_q,    imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              tx_start_q,   tx_start_d;
   logic [31:0]       tx_status_q,  tx_status_d;
   logic              rx_release_q, rx_release_d;
   logic [15:0]       to_cnt_q,     to_cnt_d;

   logic              full;
   logic              cmd_prg;
   logic              cmd_run;
   logic              cmd_halt;
   logic              cmd_known;
   logic [15:0]       cnt_ext;

   assign full      = (word_cnt_q == CNT_FULL);
   assign cmd_prg   = (bus.data_cmd == CMD_PRG);
   assign cmd_run   = (bus.data_cmd == CMD_RUN);
   assign cmd_halt  = (bus.data_cmd == CMD_HALT);
   assign cmd_known = cmd_prg | cmd_run | cmd_halt;

   // Zero-extended word count for the status word; ADDR_W <= 15 keeps it within 16 bits.
   always_comb begin
      cnt_ext             = '0;
      cnt_ext[ADDR_W:0]   = word_cnt_q;
   end

   always_comb begin
      state_d      = state_q;
      word_cnt_d   = word_cnt_q;
      ovf_d        = ovf_q;
      to_flag_d    = to_flag_q;
      cpu_rst_d    = cpu_rst_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      tx_start_d   = 1'b0;
      tx_status_d  = tx_status_q;
      rx_release_d = 1'b0;
      to_cnt_d     = to_cnt_q;

      case (state_q)
         S_IDLE: begin
            // A word arriving together with rx_finish is still written and counted,
            // so DECODE reports it.
            if (bus.data_o_valid) begin
               if (!full) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                  imem_wdata_d = bus.data_o;
                  word_cnt_d   = word_cnt_q + CNT_ONE;
                  cpu_rst_d    = 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (bus.rx_finish) begin
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            if (cmd_run) begin
               cpu_rst_d  = 1'b0;
               word_cnt_d = '0;
               ovf_d      = 1'b0;
            end else if (cmd_halt) begin
               cpu_rst_d  = 1'b1;
               word_cnt_d = '0;
               ovf_d      = 1'b0;
            end
            // Overflow and count are reported as they were before the clear;
            // cpu_rst is reported as it will be after the command.
            tx_status_d = {(cmd_known ? 8'hAC : 8'hEE), 4'h0, ovf_q, cpu_rst_d,
                           1'b0, to_flag_q, cnt_ext};
            tx_start_d  = 1'b1;
            to_cnt_d    = '0;
            state_d     = S_WAIT_TX;
         end

         S_WAIT_TX: begin
            // Every frame gets a release, either by the transmitter or by timeout,
            // so the receiver can never stall waiting for tx_finish.
            if (bus.tx_finish) begin
               rx_release_d = 1'b1;
               to_flag_d    = 1'b0;
               state_d      = S_IDLE;
            end else if (to_cnt_q == (TX_TIMEOUT - 16'd1)) begin
               rx_release_d = 1'b1;
               to_flag_d    = 1'b1;
               state_d      = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         word_cnt_q   <= '0;
         ovf_q        <= 1'b0;
         to_flag_q    <= 1'b0;
         cpu_rst_q    <= 1'b1;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         tx_start_q   <= 1'b0;
         tx_status_q  <= '0;
         rx_release_q <= 1'b0;
         to_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         ovf_q        <= ovf_d;
         to_flag_q    <= to_flag_d;
         cpu_rst_q    <= cpu_rst_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         tx_start_q   <= tx_start_d;
         tx_status_q  <= tx_status_d;
         rx_release_q <= rx_release_d;
         to_cnt_q     <= to_cnt_d;
      end
   end

   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign bus.tx_start   = tx_start_q;
   assign bus.tx_status  = tx_status_q;
   assign bus.rx_release = rx_release_q;
   assign cpu_rst        = cpu_rst_q;
   assign busy           = (state_q != S_IDLE);

endmodule
